// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the AXI4-Stream video test-pattern source.
//   pattern_e : runtime pattern selector encoding (matches pattern_sel).
//   state_e   : frame sequencer states.
//   pixel_t   : one 24-bit beat, element [0]=green, [1]=blue, [2]=red, so
//               the packed value lines up directly with m_tdata.
//   BAR_LUT   : colour-bar palette, left to right across the line.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int COORD_W  = 16;  // x / y / resolution width
    localparam int ACC_W    = 19;  // bar accumulator width
    localparam int BAR_STEP = 8;   // number of bars, also the per-pixel step
    localparam int NUM_BARS = 8;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic [2:0][7:0] pixel_t;

    localparam int CH_GREEN = 0;
    localparam int CH_BLUE  = 1;
    localparam int CH_RED   = 2;

    localparam pixel_t PIX_WHITE = 24'hFF_FF_FF;
    localparam pixel_t PIX_BLACK = 24'h00_00_00;

    // Values are written in wire order {red, blue, green}.
    localparam pixel_t BAR_LUT [NUM_BARS] = '{
        24'hFF_FF_FF,   // white
        24'hFF_00_FF,   // yellow  (red + green)
        24'h00_FF_FF,   // cyan    (green + blue)
        24'h00_00_FF,   // green
        24'hFF_FF_00,   // magenta (red + blue)
        24'hFF_00_00,   // red
        24'h00_FF_00,   // blue
        24'h00_00_00    // black
    };

    function automatic pixel_t make_pixel(input logic [7:0] red,
                                          input logic [7:0] green,
                                          input logic [7:0] blue);
        pixel_t p;
        p           = '0;
        p[CH_RED]   = red;
        p[CH_GREEN] = green;
        p[CH_BLUE]  = blue;
        return p;
    endfunction

endpackage

// File: rtl/vga_pattern_pix.sv
// ---------------------------------------------------------------------------
// vga_pattern_pix
// Purely combinational colour generator for one pixel.
//   pattern : which pattern to draw
//   x, y    : coordinates of the pixel being produced
//   bar_idx : colour-bar index for x (computed by the sequencer)
//   solid   : colour used by the solid pattern
//   pixel   : resulting colour, wire order {red, blue, green}
// ---------------------------------------------------------------------------
module vga_pattern_pix
    import vga_pkg::*;
#(
    parameter int CHECKER_LOG2 = 5
) (
    input  pattern_e             pattern,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic [2:0]           bar_idx,
    input  pixel_t               solid,
    output pixel_t               pixel
);

    logic [7:0] diag;
    logic       checker_bit;
    logic       unused_hi;

    // Gradient blue channel wraps modulo 256 by construction.
    assign diag        = x[7:0] + y[7:0];
    assign checker_bit = x[CHECKER_LOG2] ^ y[CHECKER_LOG2];
    assign unused_hi   = ^{x[COORD_W-1:8], y[COORD_W-1:8]};

    always_comb begin
        // NOTE: assign a default before the case so every path drives the
        // output; a missing branch would otherwise infer a latch.
        pixel = PIX_BLACK;
        case (pattern)
            PAT_BARS:     pixel = BAR_LUT[bar_idx];
            PAT_CHECKER:  pixel = checker_bit ? PIX_WHITE : PIX_BLACK;
            PAT_GRADIENT: pixel = make_pixel(x[7:0], y[7:0], diag);
            PAT_SOLID:    pixel = solid;
            default:      pixel = PIX_BLACK;
        endcase
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
// AXI4-Stream test-pattern source. Emits h_res x v_res frames with tuser on
// the first beat of a frame and tlast on the last beat of every line.
//   aclk, aresetn   : clock, synchronous active-low reset
//   enable          : start / keep generating frames
//   pattern_sel     : 0 bars, 1 checker, 2 gradient, 3 solid (frame start)
//   solid_color     : colour for the solid pattern (frame start)
//   h_res, v_res    : frame geometry (frame start)
//   m_tvalid/m_tready/m_tdata/m_tlast/m_tuser : AXI4-Stream master
//   busy            : a frame is in progress
// The output beat is a register; the next beat is computed combinationally
// from the coordinates held alongside it and loaded whenever the slot is
// empty or the current beat is accepted.
// ---------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int DEFAULT_PATTERN = 0,
    parameter int CHECKER_LOG2    = 5
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 enable,
    input  logic [1:0]           pattern_sel,
    input  logic [23:0]          solid_color,
    input  logic [COORD_W-1:0]   h_res,
    input  logic [COORD_W-1:0]   v_res,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [23:0]          m_tdata,
    output logic                 m_tlast,
    output logic                 m_tuser,
    output logic                 busy
);

    // Sequencer state and the coordinates of the beat sitting in the
    // output register.
    state_e               state_q, state_d;
    logic [COORD_W-1:0]   x_q, y_q;
    logic [ACC_W-1:0]     acc_q;
    logic [2:0]           bar_q;

    // Configuration latched at frame start.
    logic [COORD_W-1:0]   h_res_q, v_res_q;
    pattern_e             pat_q;
    pixel_t               solid_q;

    // Control decisions.
    logic cfg_ok;
    logic load_slot;
    logic end_of_line;
    logic end_of_frame;
    logic do_start;
    logic do_advance;
    logic do_stop;

    // Next beat.
    logic [COORD_W-1:0]   x_n, y_n, line_len_n;
    logic [ACC_W-1:0]     acc_n, acc_step;
    logic [2:0]           bar_n;
    pattern_e             pat_n;
    pixel_t               solid_n;
    pixel_t               pix_n;
    logic                 last_n;

    assign cfg_ok       = enable && (h_res != '0) && (v_res != '0);
    assign load_slot    = !m_tvalid || m_tready;
    assign end_of_line  = (x_q == h_res_q - 16'd1);
    assign end_of_frame = end_of_line && (y_q == v_res_q - 16'd1);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        do_start   = 1'b0;
        do_advance = 1'b0;
        do_stop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_ok) begin
                    do_start = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_slot) begin
                    if (end_of_frame) begin
                        // Back-to-back frames: the next frame's first beat
                        // replaces the final beat with no idle cycle.
                        if (cfg_ok) begin
                            do_start = 1'b1;
                        end else begin
                            do_stop = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        do_advance = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-beat datapath: coordinates, bar accumulator, latched config.
    // The bar index tracks floor(8*x/h_res) by adding 8 per pixel and
    // subtracting h_res once whenever the accumulator reaches it, so no
    // divider is needed. For h_res < 8 it simply steps every pixel and
    // saturates at the last bar.
    // -----------------------------------------------------------------------
    always_comb begin
        x_n        = x_q;
        y_n        = y_q;
        acc_n      = acc_q;
        bar_n      = bar_q;
        pat_n      = pat_q;
        solid_n    = solid_q;
        line_len_n = h_res_q;
        acc_step   = acc_q + ACC_W'(BAR_STEP);

        if (do_start) begin
            x_n        = '0;
            y_n        = '0;
            acc_n      = '0;
            bar_n      = '0;
            pat_n      = pattern_e'(pattern_sel);
            solid_n    = solid_color;
            line_len_n = h_res;
        end else if (end_of_line) begin
            x_n   = '0;
            y_n   = y_q + 16'd1;
            acc_n = '0;
            bar_n = '0;
        end else begin
            x_n = x_q + 16'd1;
            if (acc_step >= {3'b000, h_res_q}) begin
                acc_n = acc_step - {3'b000, h_res_q};
                bar_n = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
            end else begin
                acc_n = acc_step;
            end
        end

        last_n = (x_n == line_len_n - 16'd1);
    end

    vga_pattern_pix #(
        .CHECKER_LOG2 (CHECKER_LOG2)
    ) u_pix (
        .pattern (pat_n),
        .x       (x_n),
        .y       (y_n),
        .bar_idx (bar_n),
        .solid   (solid_n),
        .pixel   (pix_n)
    );

    // -----------------------------------------------------------------------
    // State, counters and registered output stage
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        // NOTE: every register, including the latched configuration, is
        // cleared by the synchronous reset so a mid-frame reset leaves no
        // stale coordinates or pattern behind.
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            bar_q    <= '0;
            h_res_q  <= '0;
            v_res_q  <= '0;
            pat_q    <= pattern_e'(2'(DEFAULT_PATTERN));
            solid_q  <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge values computed by the combinational logic.
            state_q <= state_d;

            if (do_start) begin
                h_res_q <= h_res;
                v_res_q <= v_res;
                pat_q   <= pat_n;
                solid_q <= solid_n;
            end

            if (do_start || do_advance) begin
                x_q      <= x_n;
                y_q      <= y_n;
                acc_q    <= acc_n;
                bar_q    <= bar_n;
                m_tvalid <= 1'b1;
                m_tdata  <= pix_n;
                m_tlast  <= last_n;
                m_tuser  <= do_start;
            end else if (do_stop) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                m_tuser  <= 1'b0;
            end
        end
    end

    assign busy = (state_q == ST_RUN);

endmodule
